// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states and
// the multiplier latency default.
package cpu_pkg;

  localparam logic [4:0] OP_STP = 5'b00000;
  localparam logic [4:0] OP_MLR = 5'b01001;

  localparam int MUL_LAT_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FE,
    S_E1,
    S_MW,
    S_E2,
    S_HALT
  } state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter timing the multiplier wait cycles.
// zero reflects the registered count.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer: drives fe/e1/e2 strobes,
// holds the IR and counts retired instructions.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int IW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] instr_in,
  input  logic          extra1,
  input  logic          pc_sload,
  output logic [IW-1:0] ir,
  output logic          fe,
  output logic          e1,
  output logic          e2,
  output logic          mwait,
  output logic          halted,
  output logic [15:0]   retired
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] WAIT_LD =
    CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

  state_t state;
  logic   is_stp;
  logic   is_mlr;
  logic   mw_load;
  logic   mw_dec;
  logic   mw_zero;

  assign is_stp = (ir[15:11] == OP_STP);
  assign is_mlr = (ir[15:11] == OP_MLR);

  assign mw_load = (state == S_E1) && !is_stp &&
                   extra1 && is_mlr && (MUL_LAT > 1);
  assign mw_dec  = (state == S_MW) && !mw_zero;

  wait_counter #(
    .W(CW)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .load    (mw_load),
    .dec     (mw_dec),
    .load_val(WAIT_LD),
    .zero    (mw_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) state <= S_FE;
        end
        S_FE: begin
          ir    <= instr_in;
          state <= S_E1;
        end
        S_E1: begin
          if (is_stp) begin
            state <= S_HALT;
          end else if (extra1) begin
            state <= mw_load ? S_MW : S_E2;
          end else if (pc_sload) begin
            // overlapped fetch is stale after a PC reload
            retired <= retired + 16'd1;
            state   <= S_FE;
          end else begin
            ir      <= instr_in;
            retired <= retired + 16'd1;
          end
        end
        S_MW: begin
          if (mw_zero) state <= S_E2;
        end
        S_E2: begin
          ir      <= instr_in;
          retired <= retired + 16'd1;
          state   <= S_E1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fe     = (state == S_FE);
  assign e1     = (state == S_E1);
  assign mwait  = (state == S_MW);
  assign e2     = (state == S_E2);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: schedule-based reference model,
// per-cycle compare plus literal anchor checks.
module tb_phase_sequencer;
  import cpu_pkg::*;

  localparam int ML = MUL_LAT_DEFAULT;

  localparam int P_IDLE = 0;
  localparam int P_FE   = 1;
  localparam int P_E1   = 2;
  localparam int P_MW   = 3;
  localparam int P_E2   = 4;
  localparam int P_HALT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr_in;
  logic        extra1;
  logic        pc_sload;
  logic [15:0] ir;
  logic        fe, e1, e2, mwait, halted;
  logic [15:0] retired;

  int n_chk  = 0;
  int n_fail = 0;

  int          m_ph;
  logic [15:0] m_ir;
  logic [15:0] m_ret;
  int          q[$];

  phase_sequencer #(
    .MUL_LAT(ML),
    .IW     (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .instr_in(instr_in),
    .extra1  (extra1),
    .pc_sload(pc_sload),
    .ir      (ir),
    .fe      (fe),
    .e1      (e1),
    .e2      (e2),
    .mwait   (mwait),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && e1)
      assert (!(extra1 && pc_sload))
        else $error("illegal extra1 with pc_sload in e1");
  end

  function automatic logic op_extra(input logic [4:0] op);
    return (op == OP_MLR) || (op == 5'b01010);
  endfunction

  function automatic logic op_jump(input logic [4:0] op);
    return op == 5'b11101;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph  = P_IDLE;
    m_ir  = '0;
    m_ret = '0;
    q.delete();
  endtask

  task automatic model_update();
    logic [4:0] op;
    if (reset) begin
      model_reset();
      return;
    end
    op = m_ir[15:11];
    case (m_ph)
      P_IDLE, P_HALT: if (start) m_ph = P_FE;
      P_FE: begin
        m_ir = instr_in;
        m_ph = P_E1;
      end
      P_E1: begin
        if (op == OP_STP) begin
          m_ph = P_HALT;
        end else if (op_extra(op)) begin
          if (op == OP_MLR)
            for (int i = 0; i < ML - 1; i++) q.push_back(P_MW);
          q.push_back(P_E2);
          m_ph = q.pop_front();
        end else if (op_jump(op)) begin
          m_ret++;
          m_ph = P_FE;
        end else begin
          m_ir = instr_in;
          m_ret++;
        end
      end
      P_MW: m_ph = q.pop_front();
      P_E2: begin
        m_ir = instr_in;
        m_ret++;
        m_ph = P_E1;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic drive_decoder();
    extra1   = (m_ph == P_E1) && op_extra(m_ir[15:11]);
    pc_sload = (m_ph == P_E1) && op_jump(m_ir[15:11]);
  endtask

  task automatic compare_cycle();
    logic [4:0] exp_s;
    exp_s = {m_ph == P_FE, m_ph == P_E1, m_ph == P_MW,
             m_ph == P_E2, m_ph == P_HALT};
    chk("cycle_strobes", {27'd0, fe, e1, mwait, e2, halted},
        {27'd0, exp_s});
    chk("cycle_ir", {16'd0, ir}, {16'd0, m_ir});
    chk("cycle_retired", {16'd0, retired}, {16'd0, m_ret});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    drive_decoder();
    @(negedge clk);
    compare_cycle();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    instr_in = '0;
    extra1   = 1'b0;
    pc_sload = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_strobes", {27'd0, fe, e1, mwait, e2, halted}, 32'd0);
    chk("reset_ir", {16'd0, ir}, 32'd0);
    chk("reset_retired", {16'd0, retired}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_no_start", {31'd0, fe}, 32'd0);

    // ADR run
    start    = 1'b1;
    instr_in = 16'h0800;
    step();
    start = 1'b0;
    chk("adr_fe", {31'd0, fe}, 32'd1);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("adr_e1", {31'd0, e1}, 32'd1);
    chk("adr_ir", {16'd0, ir}, 32'h0800);
    chk("adr_retired", {16'd0, retired}, 32'd3);

    // MLR with wait cycles
    instr_in = 16'h4800;
    step();
    chk("mlr_e1_ir", {16'd0, ir}, 32'h4800);
    instr_in = 16'h0800;
    step();
    chk("mlr_mw1", {31'd0, mwait}, 32'd1);
    step();
    chk("mlr_mw2", {31'd0, mwait}, 32'd1);
    chk("mlr_ir_held", {16'd0, ir}, 32'h4800);
    step();
    chk("mlr_e2", {31'd0, e2}, 32'd1);
    chk("mlr_ret_before", {16'd0, retired}, 32'd4);
    step();
    chk("mlr_ret_after", {16'd0, retired}, 32'd5);
    chk("mlr_next_ir", {16'd0, ir}, 32'h0800);

    // taken jump
    instr_in = 16'hE800;
    step();
    instr_in = 16'h3000;
    step();
    chk("jmp_fe", {31'd0, fe}, 32'd1);
    chk("jmp_ret", {16'd0, retired}, 32'd7);
    chk("jmp_ir_held", {16'd0, ir}, 32'hE800);
    step();
    chk("jmp_refetch_ir", {16'd0, ir}, 32'h3000);

    // STP halt and restart
    instr_in = 16'h0000;
    step();
    step();
    chk("stp_halted", {31'd0, halted}, 32'd1);
    chk("stp_ret", {16'd0, retired}, 32'd8);
    repeat (3) step();
    chk("stp_stays", {31'd0, halted}, 32'd1);
    start    = 1'b1;
    instr_in = 16'h0800;
    step();
    start = 1'b0;
    chk("restart_fe", {31'd0, fe}, 32'd1);
    step();
    chk("restart_e1", {31'd0, e1}, 32'd1);
    chk("restart_ret", {16'd0, retired}, 32'd8);

    // plain extra instruction
    instr_in = 16'h5000;
    step();
    instr_in = 16'h0800;
    step();
    chk("extra_e2", {31'd0, e2}, 32'd1);
    step();
    chk("extra_ret", {16'd0, retired}, 32'd10);

    // async reset during MW
    instr_in = 16'h4800;
    step();
    instr_in = 16'h0800;
    step();
    chk("pre_reset_mw", {31'd0, mwait}, 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_strobes", {27'd0, fe, e1, mwait, e2, halted}, 32'd0);
    chk("async_ir", {16'd0, ir}, 32'd0);
    chk("async_ret", {16'd0, retired}, 32'd0);
    step();
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_fe", {31'd0, fe}, 32'd1);
    step();
    chk("resume_e1", {31'd0, e1}, 32'd1);

    // retired wrap
    repeat (65535) step();
    chk("wrap_pre", {16'd0, retired}, 32'h0000FFFF);
    step();
    chk("wrap_post", {16'd0, retired}, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle control sequencer that drives the fe/e1/e2 phase strobes into the instruction decoder.
- Consumes the decoder's extra1 and pc_sload responses.
- Holds the instruction register (IR) whose contents the decoder sees as INSTR.
- Inserts wait cycles so the pipelined multiplier result lands in e2; handles halt on STP and refetch after a taken jump/return.

Parameters:
- MUL_LAT, 3: cycles from e1 of MLR to its e2 (MUL_LAT-1 wait cycles); legal range 1..8.
- IW, 16: instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE/HALT.
- instr_in  input  IW  instruction memory read data (word addressed by PC).
- extra1  input  1  from decoder; instruction needs an e2 phase (already gated by e1).
- pc_sload  input  1  from decoder; PC reloaded this e1 (jump taken / return).
- ir  output  IW  instruction register, feeds decoder INSTR.
- fe  output  1  fetch phase strobe.
- e1  output  1  execute-1 phase strobe.
- e2  output  1  execute-2 phase strobe.
- mwait  output  1  multiplier wait cycle in progress.
- halted  output  1  high in HALT.
- retired  output  16  completed-instruction count.

Behaviour:
- States: IDLE, FE, E1, MW, E2, HALT.
- Outputs are Moore-decoded from state and mutually exclusive: fe=FE, e1=E1, mwait=MW, e2=E2, halted=HALT.
- Reset (any time, including mid-instruction): state=IDLE, ir=0, retired=0, all strobes 0. Takes effect immediately, asynchronously.
- IDLE: start -> FE; otherwise stay.
- HALT: start -> FE; otherwise stay.
- FE: ir <= instr_in; -> E1. Single cycle, no condition.
- E1 priority: stp > extra1 > pc_sload > normal. stp means ir[15:11]==5'b00000.
  - stp: -> HALT; ir unchanged; retired unchanged.
  - extra1 and ir[15:11]==5'b01001 (MLR) and MUL_LAT>1: -> MW; load wait counter with MUL_LAT-2.
  - extra1 otherwise: -> E2.
  - pc_sload: -> FE (flushes the overlapped fetch); retired+1.
  - normal: ir <= instr_in (overlapped fetch); stay in E1; retired+1.
- MW: counter==0 -> E2; else counter-1. ir is held.
- E2: ir <= instr_in; -> E1; retired+1.
- extra1 and pc_sload together in E1 is illegal; extra1 wins, and the bench flags it via an assertion.
- start is ignored outside IDLE/HALT.
- extra1 and pc_sload are ignored outside E1.
- retired is a 16-bit counter that wraps 0xFFFF -> 0x0000.
- Latency: non-extra instruction = 1 cycle (E1); extra = 2 cycles; MLR = MUL_LAT+1 cycles; taken jump = 2 cycles (E1 + FE).

Decomposition:
- Shared package (cpu_pkg):
  - OP_STP=5'b00000, OP_MLR=5'b01001.
  - State enum encoding.
  - MUL_LAT default constant, also used by the multiplier.
- One sub-module: wait_counter (load/decrement/zero-flag, width $clog2(MUL_LAT)+1). Everything else stays in phase_sequencer.

Test Plan:
- Reset then start with instr_in=0x0800 (ADR) for 3 cycles, extra1=0 -> fe one cycle, then e1 held 3 cycles, ir=0x0800, retired=3.
- E1 with ir=0x4800 (MLR), extra1=1, MUL_LAT=3 -> e1, mwait, mwait, e2; ir constant until e2 edge; retired+1 after e2.
- E1 with ir=0xE800 (JMP), pc_sload=1 -> next cycle fe=1, ir reloaded from instr_in on the following edge, retired+1.
- ir=0x0000 in E1 -> halted=1 and stays; start pulse -> fe, then e1; retired unchanged by STP.
- Assert reset during MW -> all strobes 0 the same cycle, ir=0, retired=0; start resumes from FE.
- Preload retired=0xFFFF via 65535 single-cycle instructions, then 1 more -> retired=0x0000.
